debug_unit: RTL and testbench

//  UART-side controller in front of the mips core; host talks to the core only through it.

---
 rtl/mips_debug_pkg.sv | 29 ++
 rtl/debug_tx_serializer.sv | 61 ++++++
 rtl/debug_unit.sv | 183 ++++++++++++++++++
 tb/tb_debug_unit.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_debug_pkg.sv
// Shared definitions for the UART debug front-end of the mips core:
// host command bytes, controller state encoding and default dump length.
package mips_debug_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'
  localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'
  localparam logic [7:0] CMD_HALT  = 8'h48;  // 'H'

  localparam int DUMP_WORDS_DEF = 40;
  localparam int CNT_W          = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_CNT_H,
    ST_LD_CNT_L,
    ST_LD_BYTE,
    ST_LD_WR,
    ST_RUN,
    ST_STEP,
    ST_CPU_RST,
    ST_DMP_LOAD,
    ST_DMP_SEND,
    ST_DMP_WAIT
  } dbg_state_e;

endpackage

// File: rtl/debug_tx_serializer.sv
// Latches one debug word and hands it to the UART transmitter one byte at a
// time, MSB first; word_done_o marks the launch of the word's final byte.
module debug_tx_serializer #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [SIZE-1:0] word_i,
  input  logic            send_i,
  input  logic            tx_busy_i,
  output logic            fire_o,
  output logic            word_done_o,
  output logic [7:0]      tx_data_o,
  output logic            tx_start_o
);

  localparam int NBYTES = SIZE / 8;
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [SIZE-1:0]   shreg_q, shreg_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q;

  assign fire_o      = send_i & ~tx_busy_i;
  assign word_done_o = fire_o && (bcnt_q == BCNT_W'(NBYTES - 1));

  always_comb begin
    // NOTE: every next-state value gets its hold default first, so no path leaves a latch.
    shreg_d   = shreg_q;
    bcnt_d    = bcnt_q;
    tx_data_d = tx_data_q;
    if (load_i) begin
      shreg_d = word_i;
      bcnt_d  = '0;
    end else if (fire_o) begin
      tx_data_d = shreg_q[SIZE-1 -: 8];
      shreg_d   = {shreg_q[SIZE-9:0], 8'h00};
      bcnt_d    = bcnt_q + BCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q    <= '0;
      bcnt_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bcnt_q     <= bcnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= fire_o;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;

endmodule

// File: rtl/debug_unit.sv
// Host-facing controller for the mips core: loads instruction memory over UART,
// runs or single-steps the core via its stall, and streams back debug dumps.
module debug_unit
  import mips_debug_pkg::*;
#(
  parameter  int SIZE        = 32,
  parameter  int IMEM_ADDR_W = 10,
  parameter  int DUMP_WORDS  = DUMP_WORDS_DEF,
  localparam int DUMP_SEL_W  = $clog2(DUMP_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_busy,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [SIZE-1:0]        o_imem_wdata,
  output logic                   o_cpu_stall,
  output logic                   o_cpu_rst,
  output logic [DUMP_SEL_W-1:0]  o_dump_sel,
  input  logic [SIZE-1:0]        i_dump_data,
  input  logic                   i_halt
);

  localparam int NBYTES = SIZE / 8;
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  dbg_state_e             state_q;
  logic [CNT_W-1:0]       n_words_q;
  logic [CNT_W-1:0]       word_idx_q;
  logic [BCNT_W-1:0]      ld_bcnt_q;
  logic [SIZE-1:0]        wdata_q;
  logic                   imem_we_q;
  logic [IMEM_ADDR_W-1:0] imem_addr_q;
  logic                   stall_q;
  logic                   cpu_rst_q;
  logic [DUMP_SEL_W-1:0]  dump_sel_q;
  logic                   last_byte_q;
  logic                   wait_skip_q;

  logic ser_fire;
  logic ser_word_done;
  logic rx_halt;

  assign rx_halt = i_rx_valid && (i_rx_data == CMD_HALT);

  debug_tx_serializer #(.SIZE(SIZE)) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (state_q == ST_DMP_LOAD),
    .word_i      (i_dump_data),
    .send_i      (state_q == ST_DMP_SEND),
    .tx_busy_i   (i_tx_busy),
    .fire_o      (ser_fire),
    .word_done_o (ser_word_done),
    .tx_data_o   (o_tx_data),
    .tx_start_o  (o_tx_start)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_words_q   <= '0;
      word_idx_q  <= '0;
      ld_bcnt_q   <= '0;
      wdata_q     <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      stall_q     <= 1'b1;
      cpu_rst_q   <= 1'b0;
      dump_sel_q  <= '0;
      last_byte_q <= 1'b0;
      wait_skip_q <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      cpu_rst_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: state_q <= ST_LD_CNT_H;
              CMD_CONT: begin
                if (i_halt) begin
                  state_q <= ST_DMP_LOAD;
                end else begin
                  stall_q <= 1'b0;
                  state_q <= ST_RUN;
                end
              end
              CMD_STEP: begin
                stall_q <= 1'b0;
                state_q <= ST_STEP;
              end
              CMD_DUMP:  state_q <= ST_DMP_LOAD;
              CMD_RESET: begin
                cpu_rst_q <= 1'b1;
                state_q   <= ST_CPU_RST;
              end
              default: ;
            endcase
          end
        end
        ST_LD_CNT_H: begin
          if (i_rx_valid) begin
            n_words_q[15:8] <= i_rx_data;
            state_q         <= ST_LD_CNT_L;
          end
        end
        ST_LD_CNT_L: begin
          if (i_rx_valid) begin
            n_words_q[7:0] <= i_rx_data;
            word_idx_q     <= '0;
            ld_bcnt_q      <= '0;
            state_q        <= ({n_words_q[15:8], i_rx_data} == 16'd0) ? ST_IDLE : ST_LD_BYTE;
          end
        end
        ST_LD_BYTE: begin
          if (i_rx_valid) begin
            wdata_q   <= {wdata_q[SIZE-9:0], i_rx_data};
            ld_bcnt_q <= ld_bcnt_q + BCNT_W'(1);
            if (ld_bcnt_q == BCNT_W'(NBYTES - 1)) begin
              imem_we_q   <= 1'b1;
              imem_addr_q <= word_idx_q[IMEM_ADDR_W-1:0];
              state_q     <= ST_LD_WR;
            end
          end
        end
        ST_LD_WR: begin
          ld_bcnt_q  <= '0;
          word_idx_q <= word_idx_q + CNT_W'(1);
          state_q    <= (word_idx_q == n_words_q - CNT_W'(1)) ? ST_IDLE : ST_LD_BYTE;
        end
        ST_RUN: begin
          if (i_halt || rx_halt) begin
            stall_q <= 1'b1;
            state_q <= ST_DMP_LOAD;
          end
        end
        ST_STEP: begin
          stall_q <= 1'b1;
          state_q <= ST_DMP_LOAD;
        end
        ST_CPU_RST:  state_q <= ST_IDLE;
        ST_DMP_LOAD: state_q <= ST_DMP_SEND;
        ST_DMP_SEND: begin
          if (ser_fire) begin
            last_byte_q <= ser_word_done;
            wait_skip_q <= 1'b1;
            state_q     <= ST_DMP_WAIT;
          end
        end
        ST_DMP_WAIT: begin
          // The transmitter only raises busy a cycle after the start pulse.
          if (wait_skip_q) begin
            wait_skip_q <= 1'b0;
          end else if (!i_tx_busy) begin
            if (!last_byte_q) begin
              state_q <= ST_DMP_SEND;
            end else if (dump_sel_q == DUMP_SEL_W'(DUMP_WORDS - 1)) begin
              dump_sel_q <= '0;
              state_q    <= ST_IDLE;
            end else begin
              dump_sel_q <= dump_sel_q + DUMP_SEL_W'(1);
              state_q    <= ST_DMP_LOAD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_imem_we    = imem_we_q;
  assign o_imem_addr  = imem_addr_q;
  assign o_imem_wdata = wdata_q;
  assign o_cpu_stall  = stall_q;
  assign o_cpu_rst    = cpu_rst_q;
  assign o_dump_sel   = dump_sel_q;

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: a UART transmitter model, a debug-word mux
// model, and one task per host command scenario.
module tb_debug_unit;

  localparam int DUMP_BYTES = 160;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_stall;
  logic        cpu_rst;
  logic [5:0]  dump_sel;
  logic [31:0] dump_data;
  logic        halt = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  debug_unit dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .i_tx_busy    (tx_busy),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_cpu_stall  (cpu_stall),
    .o_cpu_rst    (cpu_rst),
    .o_dump_sel   (dump_sel),
    .i_dump_data  (dump_data),
    .i_halt       (halt)
  );

  function automatic logic [31:0] dump_model(input logic [5:0] sel);
    logic [7:0] s;
    s = {2'b00, sel};
    return {s + 8'h10, 8'hA5, s ^ 8'h5A, s | 8'hC0};
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    w = dump_model(6'(i / 4));
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  assign dump_data = dump_model(dump_sel);

  // Environment monitor: transmitter with a 6-cycle busy window, plus logs.
  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic [7:0] tx_q[$];
  wr_t        wr_q[$];
  int         busy_cnt = 0;
  int         stall_low_cnt = 0;
  int         cpu_rst_cnt = 0;
  int         busy_viol = 0;

  assign tx_busy = (busy_cnt != 0);

  always @(negedge clk) begin
    if (tx_start) begin
      if (tx_busy) busy_viol <= busy_viol + 1;
      tx_q.push_back(tx_data);
      busy_cnt <= 6;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (imem_we) wr_q.push_back('{imem_addr, imem_wdata});
    if (!cpu_stall) stall_low_cnt <= stall_low_cnt + 1;
    if (cpu_rst) cpu_rst_cnt <= cpu_rst_cnt + 1;
  end

  task automatic clear_mon();
    @(posedge clk);
    tx_q.delete();
    wr_q.delete();
    stall_low_cnt = 0;
    cpu_rst_cnt = 0;
    busy_viol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic collect_dump(output int nbytes, output int nbad);
    int budget;
    budget = 0;
    while (tx_q.size() < DUMP_BYTES && budget < 6000) begin
      @(negedge clk);
      budget++;
    end
    repeat (15) @(negedge clk);
    nbytes = tx_q.size();
    nbad = 0;
    for (int i = 0; i < nbytes && i < DUMP_BYTES; i++)
      if (tx_q[i] !== exp_byte(i)) nbad++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({cpu_stall, tx_start, imem_we, cpu_rst} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 1000", {cpu_stall, tx_start, imem_we, cpu_rst});
    end
    tests_run++;
    if ({imem_addr, imem_wdata, dump_sel, tx_data} !== 56'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h want 0", {imem_addr, imem_wdata, dump_sel, tx_data});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (cpu_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_idle_stall: got %b want 1", cpu_stall);
    end
  endtask

  task automatic test_load();
    logic [7:0] bytes [11];
    bytes = '{8'h4C, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};
    clear_mon();
    foreach (bytes[i]) send_byte(bytes[i], 10);
    repeat (10) @(negedge clk);
    tests_run++;
    if (wr_q.size() !== 2) begin
      tests_failed++;
      $display("FAIL load_count: got %0d want 2", wr_q.size());
    end
    tests_run++;
    if (wr_q.size() < 1 || wr_q[0] !== {10'd0, 32'h20010005}) begin
      tests_failed++;
      $display("FAIL load_word0: got %h want %h", wr_q.size() > 0 ? wr_q[0] : 42'h0, {10'd0, 32'h20010005});
    end
    tests_run++;
    if (wr_q.size() < 2 || wr_q[1] !== {10'd1, 32'hAC010000}) begin
      tests_failed++;
      $display("FAIL load_word1: got %h want %h", wr_q.size() > 1 ? wr_q[1] : 42'h0, {10'd1, 32'hAC010000});
    end
    tests_run++;
    if (tx_q.size() !== 0 || cpu_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_side: got tx=%0d stall=%b want tx=0 stall=1", tx_q.size(), cpu_stall);
    end
  endtask

  task automatic test_zero_load_dump();
    int nbytes, nbad, budget;
    clear_mon();
    send_byte(8'h4C, 10);
    send_byte(8'h00, 10);
    send_byte(8'h00, 10);
    repeat (10) @(negedge clk);
    tests_run++;
    if (wr_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL zero_load_writes: got %0d want 0", wr_q.size());
    end
    send_byte(8'h44, 0);
    budget = 0;
    while (tx_q.size() < 8 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    send_byte(8'h52, 10);  // must be dropped mid-dump
    collect_dump(nbytes, nbad);
    tests_run++;
    if (nbytes !== DUMP_BYTES) begin
      tests_failed++;
      $display("FAIL dump_len: got %0d want %0d", nbytes, DUMP_BYTES);
    end
    tests_run++;
    if ({tx_q[0], tx_q[1], tx_q[2], tx_q[3]} !== 32'h10A55AC0) begin
      tests_failed++;
      $display("FAIL dump_word0: got %h want 10a55ac0", {tx_q[0], tx_q[1], tx_q[2], tx_q[3]});
    end
    tests_run++;
    if (nbad !== 0) begin
      tests_failed++;
      $display("FAIL dump_bytes: got %0d bad want 0", nbad);
    end
    tests_run++;
    if ({cpu_rst_cnt, busy_viol, stall_low_cnt} !== {32'd0, 32'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL dump_side: got rst=%0d viol=%0d low=%0d want 0 0 0", cpu_rst_cnt, busy_viol, stall_low_cnt);
    end
    tests_run++;
    if (dump_sel !== 6'd0) begin
      tests_failed++;
      $display("FAIL dump_sel_end: got %0d want 0", dump_sel);
    end
  endtask

  task automatic test_ignored();
    clear_mon();
    send_byte(8'h48, 10);
    send_byte(8'h5A, 10);
    send_byte(8'h00, 10);
    repeat (20) @(negedge clk);
    tests_run++;
    if ({tx_q.size(), wr_q.size(), stall_low_cnt, cpu_rst_cnt} !== 128'd0) begin
      tests_failed++;
      $display("FAIL ignored: got tx=%0d wr=%0d low=%0d rst=%0d want 0", tx_q.size(), wr_q.size(), stall_low_cnt, cpu_rst_cnt);
    end
  endtask

  task automatic test_step();
    int nbytes, nbad;
    clear_mon();
    send_byte(8'h53, 0);
    collect_dump(nbytes, nbad);
    tests_run++;
    if (stall_low_cnt !== 1) begin
      tests_failed++;
      $display("FAIL step_stall: got %0d low cycles want 1", stall_low_cnt);
    end
    tests_run++;
    if (nbytes !== DUMP_BYTES || nbad !== 0) begin
      tests_failed++;
      $display("FAIL step_dump: got %0d bytes %0d bad want %0d 0", nbytes, nbad, DUMP_BYTES);
    end
    tests_run++;
    if (busy_viol !== 0) begin
      tests_failed++;
      $display("FAIL step_busy: got %0d starts while busy want 0", busy_viol);
    end
  endtask

  task automatic test_continue_halt();
    int nbytes, nbad;
    clear_mon();
    send_byte(8'h43, 0);
    repeat (49) @(negedge clk);
    halt = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (cpu_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL cont_stall_back: got %b want 1", cpu_stall);
    end
    halt = 1'b0;
    collect_dump(nbytes, nbad);
    tests_run++;
    if (stall_low_cnt !== 50) begin
      tests_failed++;
      $display("FAIL cont_stall_low: got %0d want 50", stall_low_cnt);
    end
    tests_run++;
    if (nbytes !== DUMP_BYTES || nbad !== 0) begin
      tests_failed++;
      $display("FAIL cont_dump: got %0d bytes %0d bad want %0d 0", nbytes, nbad, DUMP_BYTES);
    end
  endtask

  task automatic test_continue_halted();
    int nbytes, nbad;
    clear_mon();
    halt = 1'b1;
    send_byte(8'h43, 0);
    collect_dump(nbytes, nbad);
    halt = 1'b0;
    tests_run++;
    if (stall_low_cnt !== 0) begin
      tests_failed++;
      $display("FAIL halted_stall: got %0d low cycles want 0", stall_low_cnt);
    end
    tests_run++;
    if (nbytes !== DUMP_BYTES || nbad !== 0) begin
      tests_failed++;
      $display("FAIL halted_dump: got %0d bytes %0d bad want %0d 0", nbytes, nbad, DUMP_BYTES);
    end
  endtask

  task automatic test_host_halt();
    int nbytes, nbad;
    clear_mon();
    send_byte(8'h43, 0);
    repeat (29) @(negedge clk);
    send_byte(8'h48, 10);
    collect_dump(nbytes, nbad);
    tests_run++;
    if (stall_low_cnt !== 31 || cpu_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL host_halt_stall: got low=%0d stall=%b want 31 1", stall_low_cnt, cpu_stall);
    end
    tests_run++;
    if (nbytes !== DUMP_BYTES || nbad !== 0) begin
      tests_failed++;
      $display("FAIL host_halt_dump: got %0d bytes %0d bad want %0d 0", nbytes, nbad, DUMP_BYTES);
    end
  endtask

  task automatic test_cpu_reset();
    clear_mon();
    send_byte(8'h52, 20);
    tests_run++;
    if (cpu_rst_cnt !== 1) begin
      tests_failed++;
      $display("FAIL cpu_rst_pulse: got %0d cycles want 1", cpu_rst_cnt);
    end
    tests_run++;
    if (tx_q.size() !== 0 || stall_low_cnt !== 0) begin
      tests_failed++;
      $display("FAIL cpu_rst_side: got tx=%0d low=%0d want 0 0", tx_q.size(), stall_low_cnt);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] first [5];
    logic [7:0] second [7];
    first  = '{8'h4C, 8'h00, 8'h01, 8'hDE, 8'hAD};
    second = '{8'h4C, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    clear_mon();
    foreach (first[i]) send_byte(first[i], 10);
    tests_run++;
    if (imem_wdata !== 32'h0000DEAD) begin
      tests_failed++;
      $display("FAIL partial_shift: got %h want 0000dead", imem_wdata);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({cpu_stall, imem_we, imem_wdata} !== {1'b1, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL async_reset: got stall=%b we=%b wdata=%h want 1 0 0", cpu_stall, imem_we, imem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    foreach (second[i]) send_byte(second[i], 10);
    repeat (10) @(negedge clk);
    tests_run++;
    if (wr_q.size() !== 1 || wr_q[0] !== {10'd0, 32'h11223344}) begin
      tests_failed++;
      $display("FAIL reload: got n=%0d first=%h want 1 %h", wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 42'h0, {10'd0, 32'h11223344});
    end
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_zero_load_dump();
    test_ignored();
    test_step();
    test_continue_halt();
    test_continue_halted();
    test_host_halt();
    test_cpu_reset();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
